// File: rtl/flex_queue_if.sv
// Valid/ready handshake bundle for flex_queue: producer side (recv) and consumer side (send).
// The queue takes the slave view; the surrounding logic takes the master view.
interface flex_queue_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] recv_msg;
    logic             recv_val;
    logic             recv_rdy;
    logic [WIDTH-1:0] send_msg;
    logic             send_val;
    logic             send_rdy;

    modport master (
        output recv_msg, recv_val, send_rdy,
        input  recv_rdy, send_msg, send_val
    );

    modport slave (
        input  recv_msg, recv_val, send_rdy,
        output recv_rdy, send_msg, send_val
    );
endinterface

// File: rtl/flex_queue.sv
// Parametrised valid/ready FIFO with arbitrary depth, normal/pipe/bypass flow modes,
// synchronous flush, occupancy count and almost-full flag.
module flex_queue #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned MODE         = 0,
    parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    flex_queue_if.slave                  q,
    output logic [$clog2(DEPTH + 1)-1:0] count,
    output logic                         almost_full
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FullCount  = CW'(DEPTH);
    localparam logic [CW-1:0] AfullCount = CW'(AFULL_THRESH);
    localparam logic [PW-1:0] LastPtr    = PW'(DEPTH - 1);
    localparam bit IsPipe   = (MODE == 1);
    localparam bit IsBypass = (MODE == 2);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic full, empty, active;
    logic recv_rdy, send_val;
    logic enq, deq, pass_through, enq_store, deq_store;

    always_comb begin
        full   = (count_q == FullCount);
        empty  = (count_q == '0);
        active = !reset && !flush;

        recv_rdy = active && (!full || (IsPipe && q.send_rdy));
        send_val = active && (!empty || (IsBypass && q.recv_val));

        enq = q.recv_val && recv_rdy;
        deq = send_val && q.send_rdy;

        // Bypass with an empty queue hands the payload straight across without touching storage.
        pass_through = IsBypass && empty && enq && deq;
        enq_store    = enq && !pass_through;
        deq_store    = deq && !pass_through;

        head_d  = deq_store ? ((head_q == LastPtr) ? '0 : head_q + 1'b1) : head_q;
        tail_d  = enq_store ? ((tail_q == LastPtr) ? '0 : tail_q + 1'b1) : tail_q;
        count_d = count_q + CW'(enq_store) - CW'(deq_store);
    end

    assign q.recv_rdy  = recv_rdy;
    assign q.send_val  = send_val;
    assign q.send_msg  = (IsBypass && empty) ? q.recv_msg : mem_q[head_q];
    assign count       = reset ? '0 : count_q;
    assign almost_full = !reset && (count_q >= AfullCount);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; enq_store is already gated off by reset and flush.
    always_ff @(posedge clk) begin
        if (enq_store) begin
            mem_q[tail_q] <= q.recv_msg;
        end
    end
endmodule

// File: tb/tb_flex_queue.sv
// Directed bench for flex_queue: table-driven wrap test on DEPTH=5 plus hand-written
// sequences for fill/drain, pipe full-throughput, bypass, flush and reset.
`timescale 1ns/1ps
module tb_flex_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush_n16 = 1'b0, flush_n5 = 1'b0, flush_p4 = 1'b0, flush_b4 = 1'b0;
    logic [4:0] count_n16;
    logic [2:0] count_n5, count_p4, count_b4;
    logic af_n16, af_n5, af_p4, af_b4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flex_queue_if #(.WIDTH(8)) if_n16 ();
    flex_queue_if #(.WIDTH(8)) if_n5 ();
    flex_queue_if #(.WIDTH(8)) if_p4 ();
    flex_queue_if #(.WIDTH(8)) if_b4 ();

    flex_queue #(.WIDTH(8), .DEPTH(16), .MODE(0)) u_n16 (
        .clk(clk), .reset(reset), .flush(flush_n16), .q(if_n16),
        .count(count_n16), .almost_full(af_n16)
    );
    flex_queue #(.WIDTH(8), .DEPTH(5), .MODE(0)) u_n5 (
        .clk(clk), .reset(reset), .flush(flush_n5), .q(if_n5),
        .count(count_n5), .almost_full(af_n5)
    );
    flex_queue #(.WIDTH(8), .DEPTH(4), .MODE(1)) u_p4 (
        .clk(clk), .reset(reset), .flush(flush_p4), .q(if_p4),
        .count(count_p4), .almost_full(af_p4)
    );
    flex_queue #(.WIDTH(8), .DEPTH(4), .MODE(2)) u_b4 (
        .clk(clk), .reset(reset), .flush(flush_b4), .q(if_b4),
        .count(count_b4), .almost_full(af_b4)
    );

    typedef struct {
        logic       val;
        logic [7:0] msg;
        logic       srdy;
        logic       exp_rdy;
        logic       exp_sval;
        logic [7:0] exp_msg;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pre-edge state for each cycle of 12 enq cycles (alternating send_rdy) then a drain.
        vecs[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        vecs[1]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h10, 1};
        vecs[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'h11, 1};
        vecs[3]  = '{1'b1, 8'h13, 1'b1, 1'b1, 1'b1, 8'h11, 2};
        vecs[4]  = '{1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 8'h12, 2};
        vecs[5]  = '{1'b1, 8'h15, 1'b1, 1'b1, 1'b1, 8'h12, 3};
        vecs[6]  = '{1'b1, 8'h16, 1'b0, 1'b1, 1'b1, 8'h13, 3};
        vecs[7]  = '{1'b1, 8'h17, 1'b1, 1'b1, 1'b1, 8'h13, 4};
        vecs[8]  = '{1'b1, 8'h18, 1'b0, 1'b1, 1'b1, 8'h14, 4};
        vecs[9]  = '{1'b1, 8'h19, 1'b1, 1'b0, 1'b1, 8'h14, 5};
        vecs[10] = '{1'b1, 8'h1A, 1'b0, 1'b1, 1'b1, 8'h15, 4};
        vecs[11] = '{1'b1, 8'h1B, 1'b1, 1'b0, 1'b1, 8'h15, 5};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h16, 4};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h17, 3};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h18, 2};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h1A, 1};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

        if_n16.recv_val = 0; if_n16.recv_msg = 0; if_n16.send_rdy = 0;
        if_n5.recv_val  = 0; if_n5.recv_msg  = 0; if_n5.send_rdy  = 0;
        if_p4.recv_val  = 0; if_p4.recv_msg  = 0; if_p4.send_rdy  = 0;
        if_b4.recv_val  = 0; if_b4.recv_msg  = 0; if_b4.send_rdy  = 0;

        step();
        if_n16.recv_val = 1;
        #1;
        chk("reset_recv_rdy", 32'(if_n16.recv_rdy), 0);
        chk("reset_send_val", 32'(if_n16.send_val), 0);
        if_n16.recv_val = 0;
        step();
        reset = 0;

        // First cycle after reset.
        #1;
        chk("post_reset_recv_rdy", 32'(if_n16.recv_rdy), 1);
        chk("post_reset_send_val", 32'(if_n16.send_val), 0);
        chk("post_reset_count", 32'(count_n16), 0);
        chk("post_reset_af", 32'(af_n16), 0);
        if_b4.recv_val = 1;
        #1;
        chk("post_reset_bypass_send_val", 32'(if_b4.send_val), 1);
        if_b4.recv_val = 0;
        #1;
        chk("post_reset_bypass_idle", 32'(if_b4.send_val), 0);
        step();

        // DEPTH=16 fill then drain.
        for (int i = 0; i < 16; i++) begin
            if_n16.recv_val = 1;
            if_n16.recv_msg = 8'(i);
            #1;
            chk("n16_fill_rdy", 32'(if_n16.recv_rdy), 1);
            step();
            chk("n16_fill_count", 32'(count_n16), 32'(i + 1));
            chk("n16_fill_af", 32'(af_n16), 32'((i + 1) >= 14));
        end
        if_n16.recv_msg = 8'hEE;
        #1;
        chk("n16_full_rdy", 32'(if_n16.recv_rdy), 0);
        step();
        chk("n16_full_count", 32'(count_n16), 16);
        if_n16.recv_val = 0;
        if_n16.send_rdy = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("n16_drain_val", 32'(if_n16.send_val), 1);
            chk("n16_drain_msg", 32'(if_n16.send_msg), 32'(i));
            step();
        end
        chk("n16_drain_count", 32'(count_n16), 0);
        chk("n16_drain_empty", 32'(if_n16.send_val), 0);
        if_n16.send_rdy = 0;

        // DEPTH=5 pointer-wrap table.
        for (int i = 0; i < 17; i++) begin
            if_n5.recv_val = vecs[i].val;
            if_n5.recv_msg = vecs[i].msg;
            if_n5.send_rdy = vecs[i].srdy;
            #1;
            chk("n5_recv_rdy", 32'(if_n5.recv_rdy), 32'(vecs[i].exp_rdy));
            chk("n5_send_val", 32'(if_n5.send_val), 32'(vecs[i].exp_sval));
            if (vecs[i].exp_sval) chk("n5_send_msg", 32'(if_n5.send_msg), 32'(vecs[i].exp_msg));
            chk("n5_count", 32'(count_n5), 32'(vecs[i].exp_cnt));
            chk("n5_af", 32'(af_n5), 32'(vecs[i].exp_cnt >= 3));
            step();
        end
        if_n5.send_rdy = 0;

        // Pipe DEPTH=4: full queue accepts while draining.
        for (int i = 0; i < 4; i++) begin
            if_p4.recv_val = 1;
            if_p4.recv_msg = 8'hA0 + 8'(i);
            step();
        end
        #1;
        chk("pipe_full_count", 32'(count_p4), 4);
        chk("pipe_full_rdy_blocked", 32'(if_p4.recv_rdy), 0);
        if_p4.recv_msg = 8'hB0;
        if_p4.send_rdy = 1;
        #1;
        chk("pipe_full_rdy_pass", 32'(if_p4.recv_rdy), 1);
        chk("pipe_same_cycle_msg", 32'(if_p4.send_msg), 32'hA0);
        step();
        chk("pipe_count_stays", 32'(count_p4), 4);
        if_p4.recv_val = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("pipe_drain_msg", 32'(if_p4.send_msg), (i == 3) ? 32'hB0 : 32'hA1 + 32'(i));
            step();
        end
        chk("pipe_drain_count", 32'(count_p4), 0);
        if_p4.send_rdy = 0;

        // Bypass DEPTH=4.
        if_b4.recv_val = 1;
        if_b4.recv_msg = 8'h5C;
        if_b4.send_rdy = 1;
        #1;
        chk("bypass_pass_val", 32'(if_b4.send_val), 1);
        chk("bypass_pass_msg", 32'(if_b4.send_msg), 32'h5C);
        step();
        chk("bypass_pass_count", 32'(count_b4), 0);
        if_b4.send_rdy = 0;
        step();
        chk("bypass_store_count", 32'(count_b4), 1);
        if_b4.recv_val = 0;
        if_b4.recv_msg = 8'h00;
        #1;
        chk("bypass_stored_val", 32'(if_b4.send_val), 1);
        chk("bypass_stored_msg", 32'(if_b4.send_msg), 32'h5C);
        if_b4.send_rdy = 1;
        step();
        chk("bypass_drain_count", 32'(count_b4), 0);
        if_b4.send_rdy = 0;

        // Flush on DEPTH=5 with three stored items.
        for (int i = 0; i < 3; i++) begin
            if_n5.recv_val = 1;
            if_n5.recv_msg = 8'h31 + 8'(i);
            step();
        end
        chk("flush_pre_count", 32'(count_n5), 3);
        flush_n5 = 1;
        if_n5.recv_msg = 8'h34;
        if_n5.send_rdy = 1;
        #1;
        chk("flush_recv_rdy", 32'(if_n5.recv_rdy), 0);
        chk("flush_send_val", 32'(if_n5.send_val), 0);
        step();
        flush_n5 = 0;
        if_n5.recv_val = 0;
        if_n5.send_rdy = 0;
        #1;
        chk("flush_post_count", 32'(count_n5), 0);
        chk("flush_post_val", 32'(if_n5.send_val), 0);
        if_n5.recv_val = 1;
        if_n5.recv_msg = 8'h35;
        #1;
        chk("flush_first_enq_rdy", 32'(if_n5.recv_rdy), 1);
        step();
        if_n5.recv_val = 0;
        if_n5.send_rdy = 1;
        #1;
        chk("flush_first_out", 32'(if_n5.send_msg), 32'h35);
        step();
        chk("flush_final_count", 32'(count_n5), 0);
        if_n5.send_rdy = 0;

        // Reset with seven stored items and an enq in the same cycle.
        for (int i = 0; i < 7; i++) begin
            if_n16.recv_val = 1;
            if_n16.recv_msg = 8'h60 + 8'(i);
            step();
        end
        chk("rst_pre_count", 32'(count_n16), 7);
        reset = 1;
        if_n16.recv_msg = 8'h99;
        #1;
        chk("rst_during_rdy", 32'(if_n16.recv_rdy), 0);
        chk("rst_during_count", 32'(count_n16), 0);
        step();
        reset = 0;
        if_n16.recv_val = 0;
        #1;
        chk("rst_post_count", 32'(count_n16), 0);
        chk("rst_post_af", 32'(af_n16), 0);
        chk("rst_post_val", 32'(if_n16.send_val), 0);
        if_n16.recv_val = 1;
        if_n16.recv_msg = 8'h11;
        step();
        if_n16.recv_msg = 8'h22;
        step();
        if_n16.recv_val = 0;
        if_n16.send_rdy = 1;
        #1;
        chk("rst_first_out", 32'(if_n16.send_msg), 32'h11);
        step();
        #1;
        chk("rst_second_out", 32'(if_n16.send_msg), 32'h22);
        step();
        chk("rst_final_count", 32'(count_n16), 0);
        if_n16.send_rdy = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/flex_queue.md
# flex_queue

Parametrised valid/ready FIFO for the vector coprocessor datapath. It generalises the fixed normal-mode queue with:
- arbitrary (non-power-of-two) depth;
- a compile-time flow mode (normal, pipe, bypass);
- a synchronous flush;
- an occupancy count and almost-full flag.

It sits between lane-side producers and consumers (e.g. operand buffering, writeback staging) wherever back-pressure decoupling is needed.

## Interface
- WIDTH, 8, payload bits
- DEPTH, 16, entries; any integer >= 2
- MODE, 0, 0 = normal, 1 = pipe, 2 = bypass
- AFULL_THRESH, DEPTH-2, count at or above which almost_full asserts; legal range 1..DEPTH
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- flush  in  1  synchronous discard of all stored entries
- recv_msg  in  WIDTH  enqueue payload
- recv_val  in  1  producer valid
- recv_rdy  out  1  queue can accept
- send_msg  out  WIDTH  dequeue payload
- send_val  out  1  queue has data
- send_rdy  in  1  consumer ready
- count  out  $clog2(DEPTH+1)  stored entries, 0..DEPTH
- almost_full  out  1  count >= AFULL_THRESH

## Operation
- Handshake events:
  - enq fires = recv_val & recv_rdy.
  - deq fires = send_val & send_rdy.
  - Payload transfers only on a fire.
- State: head, tail (0..DEPTH-1), count, storage array (storage is not reset).
- Pointer wrap: a pointer at DEPTH-1 advances to 0. This applies to every DEPTH, including non-powers of two.
- Full/empty are derived from count only (count==DEPTH / count==0), never from a pointer compare.
- Normal mode (0):
  - recv_rdy = count<DEPTH.
  - send_val = count>0.
  - send_msg = storage[head].
- Pipe mode (1):
  - Same as normal, except recv_rdy = count<DEPTH | send_rdy.
  - When full and send_rdy, the dequeue and enqueue fire in the same cycle and count stays DEPTH.
  - recv_rdy therefore depends combinationally on send_rdy.
- Bypass mode (2):
  - send_val = count>0 | recv_val.
  - send_msg = recv_msg when count==0, else storage[head].
  - When count==0 and both fire, the payload passes straight through: no storage write, pointers and count unchanged.
  - When count==0, recv fires and send does not, the payload is stored normally.
- Simultaneous enq+deq with 0<count<DEPTH (all modes): write at tail, read at head, both pointers advance, count unchanged.
- count_next = count + enq_stored - deq_from_storage.
- Flush:
  - While flush=1: recv_rdy=0 and send_val=0, so no fires occur.
  - Next edge sets head=tail=count=0.
  - Stored data is discarded and never emitted.
- Reset:
  - Takes priority over flush and over any fire.
  - While reset=1: recv_rdy=0, send_val=0, count=0, almost_full=0.
  - After deassertion the queue is empty and idle.
- almost_full: combinational from registered count; no dependence on the current-cycle handshake.
- send_msg is don't-care when send_val=0.

## Timing
- Storage-path latency:
  - A stored entry is visible on send_msg/send_val the cycle after its enq edge.
  - Minimum latency 1 cycle in normal/pipe modes; 0 cycles in bypass mode when empty.
- count and almost_full update on the edge following the fire and reflect post-edge occupancy.
- First cycle after reset deassertion: recv_rdy=1, send_val=0 (bypass: send_val=recv_val).
- Reset asserted mid-transfer: the fire in that cycle is suppressed; nothing is enqueued or dequeued.
- Flush asserted in the same cycle as recv_val/send_rdy: no transfer. The first post-flush enq is accepted the cycle after flush drops.
- Combinational paths:
  - Pipe: send_rdy -> recv_rdy.
  - Bypass: recv_val/recv_msg -> send_val/send_msg.
  - Normal mode has no input-to-output combinational path.

## Test plan
- Normal, DEPTH=16: enqueue 0x00..0x0F with send_rdy=0.
  - recv_rdy drops after 16th fire; count=16; almost_full asserts at count=14.
  - Drain returns 0x00..0x0F in order; count returns to 0.
- Non-power-of-two DEPTH=5, normal: 12 enq/deq with alternating send_rdy; both pointers wrap at 4->0. Output order equals input order; count never exceeds 5.
- Pipe, DEPTH=4, full with 0xA0..0xA3, then recv_val=1, recv_msg=0xB0, send_rdy=1 in one cycle: deq 0xA0 and enq 0xB0 same cycle; count stays 4; the last entry of the later drain is 0xB0.
- Bypass, empty, recv_msg=0x5C, recv_val=1, send_rdy=1: send_msg=0x5C and send_val=1 in the same cycle; count stays 0.
  - Repeat with send_rdy=0: count=1 next cycle, and 0x5C is emitted later.
- Flush with count=3 and recv_val=1: recv_rdy=0 during flush; next cycle count=0, send_val=0; the 3 stored items are never emitted.
- Reset asserted with count=7 in the same cycle as an enq: next cycle count=0, almost_full=0, send_val=0; the subsequent first enq 0x11 is the first item dequeued.
